// File: rtl/mtsp_busy_pkg.sv
// Shared types for the MTSP busy monitor: FSM state encoding and
// the hold-counter width helper.
package mtsp_busy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width needed to hold values 0..hold, never less than one bit.
    function automatic int hold_width(input int hold);
        int w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mtsp_sat_counter.sv
// Saturating up-counter with synchronous reset and priority clear.
// Ports: clk, rst (sync, active-high), clr, inc -> count[WIDTH-1:0].
module mtsp_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mtsp_busy_monitor.sv
// Multi-core busy aggregator with hysteresis-qualified idle, sticky
// idle IRQ, flush handshake and busy statistics.
// Ports: CLK, RST (sync high), CORE_BUSY/CORE_MASK in; BUSY, IDLE out;
// IRQ_EN/IRQ_CLR -> IDLE_IRQ; FLUSH_REQ -> FLUSH_ACK;
// CNT_CLR -> BUSY_CYCLES, ACTIVE_MASK.
module mtsp_busy_monitor
    import mtsp_busy_pkg::*;
#(
    parameter int CORE_SIZE = 4,
    parameter int IDLE_HOLD = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CORE_SIZE-1:0] CORE_BUSY,
    input  logic [CORE_SIZE-1:0] CORE_MASK,
    output logic                 BUSY,
    output logic                 IDLE,
    input  logic                 IRQ_EN,
    input  logic                 IRQ_CLR,
    output logic                 IDLE_IRQ,
    input  logic                 FLUSH_REQ,
    output logic                 FLUSH_ACK,
    input  logic                 CNT_CLR,
    output logic [CNT_WIDTH-1:0] BUSY_CYCLES,
    output logic [CORE_SIZE-1:0] ACTIVE_MASK
);

    localparam int HW = hold_width(IDLE_HOLD);
    localparam logic [HW-1:0] HOLD_LOAD =
        (IDLE_HOLD > 0) ? HW'(IDLE_HOLD - 1) : '0;

    logic [CORE_SIZE-1:0] masked_busy;
    logic                 any_busy;
    state_t               state_q, state_d;
    logic [HW-1:0]        hcnt_q, hcnt_d;
    logic                 irq_set;

    assign masked_busy = CORE_BUSY & CORE_MASK;
    assign any_busy    = |masked_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Drain aborts on any renewed busy; the hold count only runs
    // while every unmasked core stays quiet.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_busy) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (!any_busy) begin
                    if (IDLE_HOLD == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                        hcnt_d  = HOLD_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (any_busy) begin
                    state_d = ST_BUSY;
                end else if (hcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign IDLE    = (state_q == ST_IDLE);
    assign irq_set = IRQ_EN && (state_d == ST_IDLE) && (state_q != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            BUSY        <= 1'b0;
            IDLE_IRQ    <= 1'b0;
            FLUSH_ACK   <= 1'b0;
            ACTIVE_MASK <= '0;
        end else begin
            BUSY <= any_busy;
            // Set beats clear when both land on the same edge.
            if (irq_set) begin
                IDLE_IRQ <= 1'b1;
            end else if (IRQ_CLR) begin
                IDLE_IRQ <= 1'b0;
            end
            // Self-masking keeps the ack a single-cycle pulse.
            FLUSH_ACK <= FLUSH_REQ & IDLE & ~any_busy & ~FLUSH_ACK;
            if (CNT_CLR) begin
                ACTIVE_MASK <= '0;
            end else begin
                ACTIVE_MASK <= ACTIVE_MASK | masked_busy;
            end
        end
    end

    mtsp_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_busy_cnt (
        .clk  (CLK),
        .rst  (RST),
        .clr  (CNT_CLR),
        .inc  (any_busy),
        .count(BUSY_CYCLES)
    );

endmodule

// File: tb/tb_mtsp_busy_monitor.sv
// Self-checking bench for mtsp_busy_monitor: directed scenarios plus
// randomized traffic against a run-length based reference model.
module tb_mtsp_busy_monitor;

    localparam int HOLD = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  core_busy;
    logic [3:0]  core_mask;
    logic        irq_en;
    logic        irq_clr;
    logic        flush_req;
    logic        cnt_clr;
    logic        busy;
    logic        idle;
    logic        idle_irq;
    logic        flush_ack;
    logic [31:0] busy_cycles;
    logic [3:0]  active_mask;
    logic        busy2, idle2, irq2, ack2;
    logic [1:0]  bc2;
    logic [3:0]  am2;

    int compared;
    int mismatched;

    // Reference state
    bit          m_clean;
    int          m_run;
    bit          m_idle;
    bit          m_irq;
    bit          m_ack;
    bit          m_busy;
    longint      m_bc;
    int          m_bc2;
    logic [3:0]  m_am;

    mtsp_busy_monitor #(
        .CORE_SIZE(4), .IDLE_HOLD(HOLD), .CNT_WIDTH(32)
    ) dut (
        .CLK(clk), .RST(rst), .CORE_BUSY(core_busy), .CORE_MASK(core_mask),
        .BUSY(busy), .IDLE(idle), .IRQ_EN(irq_en), .IRQ_CLR(irq_clr),
        .IDLE_IRQ(idle_irq), .FLUSH_REQ(flush_req), .FLUSH_ACK(flush_ack),
        .CNT_CLR(cnt_clr), .BUSY_CYCLES(busy_cycles),
        .ACTIVE_MASK(active_mask)
    );

    mtsp_busy_monitor #(
        .CORE_SIZE(4), .IDLE_HOLD(HOLD), .CNT_WIDTH(2)
    ) dut2 (
        .CLK(clk), .RST(rst), .CORE_BUSY(core_busy), .CORE_MASK(core_mask),
        .BUSY(busy2), .IDLE(idle2), .IRQ_EN(irq_en), .IRQ_CLR(irq_clr),
        .IDLE_IRQ(irq2), .FLUSH_REQ(flush_req), .FLUSH_ACK(ack2),
        .CNT_CLR(cnt_clr), .BUSY_CYCLES(bc2), .ACTIVE_MASK(am2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: advance the model with the inputs seen at the edge,
    // then settle so outputs can be sampled away from the edge.
    task automatic tick();
        bit ab;
        bit idle_n;
        @(posedge clk);
        ab = |(core_busy & core_mask);
        if (rst) begin
            m_clean = 1; m_run = 0; m_idle = 1; m_irq = 0; m_ack = 0;
            m_busy = 0; m_bc = 0; m_bc2 = 0; m_am = '0;
        end else begin
            m_ack = flush_req && m_idle && !ab && !m_ack;
            if (ab) begin
                m_clean = 0;
                m_run = 0;
            end else if (m_run < 1000) begin
                m_run++;
            end
            idle_n = m_clean || (m_run >= HOLD + 1);
            if (irq_en && !m_idle && idle_n) m_irq = 1;
            else if (irq_clr) m_irq = 0;
            m_idle = idle_n;
            m_busy = ab;
            if (cnt_clr) begin
                m_bc = 0; m_bc2 = 0; m_am = '0;
            end else begin
                if (ab && m_bc < 64'hFFFF_FFFF) m_bc++;
                if (ab && m_bc2 < 3) m_bc2++;
                m_am = m_am | (core_busy & core_mask);
            end
        end
        #1;
    endtask

    function automatic logic [41:0] dut_vec();
        return {busy, idle, idle_irq, flush_ack, active_mask, busy_cycles, bc2};
    endfunction

    function automatic logic [41:0] model_vec();
        return {m_busy, m_idle, m_irq, m_ack, m_am, m_bc[31:0], 2'(m_bc2)};
    endfunction

    task automatic test_reset();
        rst = 1; core_busy = '0; core_mask = 4'hF; irq_en = 0;
        irq_clr = 0; flush_req = 0; cnt_clr = 0;
        repeat (3) tick();
        rst = 0;
        tick();
        compared++;
        if ({busy, idle, idle_irq, flush_ack, busy_cycles, active_mask}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0}) begin
            mismatched++;
            $display("FAIL reset: got b=%0b i=%0b irq=%0b ack=%0b bc=%0d am=%h want 0 1 0 0 0 0",
                     busy, idle, idle_irq, flush_ack, busy_cycles, active_mask);
        end
    endtask

    task automatic test_basic();
        core_mask = 4'hF; irq_en = 1;
        core_busy = 4'h2;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if (busy !== 1'b1 || idle !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_busy[%0d]: busy=%0b idle=%0b want 1 0", i, busy, idle);
            end
        end
        core_busy = 4'h0;
        for (int i = 1; i <= HOLD + 1; i++) begin
            tick();
            compared++;
            if (idle !== (i == HOLD + 1) || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_drain[%0d]: idle=%0b busy=%0b want %0b 0",
                         i, idle, busy, i == HOLD + 1);
            end
        end
        compared++;
        if ({idle_irq, busy_cycles, active_mask} !== {1'b1, 32'd5, 4'h2}) begin
            mismatched++;
            $display("FAIL basic_stats: irq=%0b bc=%0d am=%h want 1 5 2",
                     idle_irq, busy_cycles, active_mask);
        end
    endtask

    task automatic test_drain_abort();
        irq_clr = 1; tick(); irq_clr = 0;
        core_busy = 4'h1;
        repeat (2) tick();
        core_busy = 4'h0;
        repeat (5) tick();
        core_busy = 4'h8;
        tick();
        core_busy = 4'h0;
        compared++;
        if (idle !== 1'b0 || idle_irq !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_pulse: idle=%0b irq=%0b want 0 0", idle, idle_irq);
        end
        for (int i = 1; i <= HOLD + 1; i++) begin
            tick();
            compared++;
            if (idle !== (i == HOLD + 1) || idle_irq !== (i == HOLD + 1)) begin
                mismatched++;
                $display("FAIL abort_drain[%0d]: idle=%0b irq=%0b want %0b",
                         i, idle, idle_irq, i == HOLD + 1);
            end
        end
    endtask

    task automatic test_mask();
        logic [31:0] bc0;
        cnt_clr = 1; tick(); cnt_clr = 0;
        bc0 = busy_cycles;
        core_mask = 4'h1; core_busy = 4'hE;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if ({busy, idle, active_mask, busy_cycles} !== {1'b0, 1'b1, 4'h0, bc0}) begin
                mismatched++;
                $display("FAIL mask[%0d]: busy=%0b idle=%0b am=%h bc=%0d want 0 1 0 %0d",
                         i, busy, idle, active_mask, busy_cycles, bc0);
            end
        end
        core_busy = 4'h0; core_mask = 4'hF;
    endtask

    task automatic test_sat_clear();
        cnt_clr = 1; tick(); cnt_clr = 0;
        core_busy = 4'h4;
        repeat (6) tick();
        compared++;
        if (bc2 !== 2'd3 || busy_cycles !== 32'd6) begin
            mismatched++;
            $display("FAIL sat: bc2=%0d bc=%0d want 3 6", bc2, busy_cycles);
        end
        cnt_clr = 1; tick(); cnt_clr = 0;
        compared++;
        if (bc2 !== 2'd0 || busy_cycles !== 32'd0) begin
            mismatched++;
            $display("FAIL clr_edge: bc2=%0d bc=%0d want 0 0", bc2, busy_cycles);
        end
        tick();
        compared++;
        if (bc2 !== 2'd1 || busy_cycles !== 32'd1) begin
            mismatched++;
            $display("FAIL clr_next: bc2=%0d bc=%0d want 1 1", bc2, busy_cycles);
        end
        irq_clr = 1; tick(); irq_clr = 0;
        core_busy = 4'h0;
        repeat (HOLD) tick();
        irq_clr = 1;
        tick();
        irq_clr = 0;
        compared++;
        if (idle !== 1'b1 || idle_irq !== 1'b1) begin
            mismatched++;
            $display("FAIL set_over_clr: idle=%0b irq=%0b want 1 1", idle, idle_irq);
        end
    endtask

    task automatic test_flush();
        int acks;
        core_busy = 4'h3;
        flush_req = 1;
        repeat (3) tick();
        core_busy = 4'h0;
        for (int i = 1; i <= HOLD + 1; i++) begin
            tick();
            compared++;
            if (flush_ack !== 1'b0) begin
                mismatched++;
                $display("FAIL flush_early[%0d]: ack=%0b want 0", i, flush_ack);
            end
        end
        tick();
        compared++;
        if (flush_ack !== 1'b1 || idle !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_ack: ack=%0b idle=%0b want 1 1", flush_ack, idle);
        end
        flush_req = 0;
        acks = 0;
        repeat (4) begin
            tick();
            if (flush_ack === 1'b1) acks++;
        end
        compared++;
        if (acks != 0) begin
            mismatched++;
            $display("FAIL flush_drop: extra acks=%0d want 0", acks);
        end
        irq_clr = 1; tick(); irq_clr = 0;
        core_busy = 4'h1;
        repeat (2) tick();
        core_busy = 4'h0;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        compared++;
        if ({idle, idle_irq, busy, busy_cycles} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            mismatched++;
            $display("FAIL rst_drain: idle=%0b irq=%0b busy=%0b bc=%0d want 1 0 0 0",
                     idle, idle_irq, busy, busy_cycles);
        end
    endtask

    task automatic test_random();
        int prob;
        for (int p = 0; p < 30; p++) begin
            prob = $urandom_range(0, 2);
            for (int c = 0; c < 25; c++) begin
                core_busy = (prob == 0) ? 4'h0 :
                            ($urandom_range(0, 3) < prob) ? 4'($urandom) : 4'h0;
                core_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                irq_en    = ($urandom_range(0, 3) != 0);
                irq_clr   = ($urandom_range(0, 9) == 0);
                flush_req = ($urandom_range(0, 2) == 0) ? !flush_req : flush_req;
                cnt_clr   = ($urandom_range(0, 40) == 0);
                rst       = ($urandom_range(0, 150) == 0);
                tick();
                compared++;
                if (dut_vec() !== model_vec()) begin
                    mismatched++;
                    $display("FAIL random[%0d.%0d]: got %h want %h",
                             p, c, dut_vec(), model_vec());
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_drain_abort();
        test_mask();
        test_sat_clear();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
